// File: rtl/d_mem_arbiter.sv
// Two-master round-robin arbiter for the single data-memory port.
// Each grant latches the winner's access, runs exactly one memory transaction,
// routes the acknowledge back to the winner, then forces one req-low cycle
// (RELEASE) so the memory's registered ready flag can clear.

module d_mem_arbiter #(
    parameter int unsigned d_addr_width = 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    m0_req,
    input  logic                    m0_dir,
    input  logic [d_addr_width-1:0] m0_addr,
    input  logic [7:0]              m0_wdata,
    output logic                    m0_ack,
    output logic [7:0]              m0_rdata,

    input  logic                    m1_req,
    input  logic                    m1_dir,
    input  logic [d_addr_width-1:0] m1_addr,
    input  logic [7:0]              m1_wdata,
    output logic                    m1_ack,
    output logic [7:0]              m1_rdata,

    output logic                    d_req,
    output logic                    d_dir,
    output logic [d_addr_width-1:0] d_addr,
    output logic [7:0]              d_wdata,
    input  logic                    d_ack,
    input  logic [7:0]              d_rdata
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StBusy    = 2'd1,
        StRelease = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic                    dir_q, dir_d;
    logic [d_addr_width-1:0] addr_q, addr_d;
    logic [7:0]              wdata_q, wdata_d;

    logic                    win_valid;
    logic                    win_sel;

    // Round-robin pick: a lone requester wins; on a tie the master not served last wins.
    always_comb begin
        win_valid = m0_req | m1_req;
        if (m0_req && m1_req) begin
            win_sel = ~last_grant_q;
        end else begin
            win_sel = m1_req;
        end
    end

    // Next-state logic; the access is latched only at the moment of a win.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        dir_d        = dir_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        unique case (state_q)
            StIdle, StRelease: begin
                if (win_valid) begin
                    state_d      = StBusy;
                    grant_d      = win_sel;
                    last_grant_d = win_sel;
                    dir_d        = win_sel ? m1_dir   : m0_dir;
                    addr_d       = win_sel ? m1_addr  : m0_addr;
                    wdata_d      = win_sel ? m1_wdata : m0_wdata;
                end else begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                if (d_ack) begin
                    state_d = StRelease;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and latched-access registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            dir_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            dir_q        <= dir_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Memory port drives latched values; ack is steered combinationally to the winner.
    always_comb begin
        d_req    = (state_q == StBusy);
        d_dir    = dir_q;
        d_addr   = addr_q;
        d_wdata  = wdata_q;
        m0_ack   = d_req & ~grant_q & d_ack;
        m1_ack   = d_req &  grant_q & d_ack;
        m0_rdata = d_rdata;
        m1_rdata = d_rdata;
    end

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Testbench for d_mem_arbiter: directed scenarios followed by random
// single/dual-master traffic, checked against a round-robin + memory-image model.

module tb_d_mem_arbiter;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_req, m0_dir, m0_ack;
    logic [7:0] m0_addr, m0_wdata, m0_rdata;
    logic       m1_req, m1_dir, m1_ack;
    logic [7:0] m1_addr, m1_wdata, m1_rdata;
    logic       d_req, d_dir, d_ack;
    logic [7:0] d_addr, d_wdata, d_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int model_last;              // master served most recently, per the model
    logic [7:0] exp_mem [256];   // expected memory image

    d_mem_arbiter #(.d_addr_width(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_dir   (m0_dir),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_dir   (m1_dir),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .d_req    (d_req),
        .d_dir    (d_dir),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata)
    );

    always #5 clk = ~clk;

    // Data memory with a registered ready flag: one access per req-high burst.
    logic [7:0] mem [256] = '{default: 8'h00};
    logic       ready_q   = 1'b0;
    logic [7:0] rdata_q   = 8'h00;

    always_ff @(posedge clk) begin
        if (d_req && !ready_q) begin
            ready_q <= 1'b1;
            rdata_q <= mem[d_addr];
            if (d_dir) mem[d_addr] <= d_wdata;
        end else begin
            ready_q <= 1'b0;
        end
    end

    assign d_ack   = ready_q;
    assign d_rdata = rdata_q;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic req, input logic dir, input logic [7:0] a,
                          input logic [7:0] w);
        m0_req = req; m0_dir = dir; m0_addr = a; m0_wdata = w;
    endtask

    task automatic set_m1(input logic req, input logic dir, input logic [7:0] a,
                          input logic [7:0] w);
        m1_req = req; m1_dir = dir; m1_addr = a; m1_wdata = w;
    endtask

    // Issue one access per requesting master and check service order and data.
    task automatic run_pair(input logic r0, input logic r1,
                            input logic dir0, input logic dir1,
                            input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] w0, input logic [7:0] w1);
        logic pend0, pend1;
        int   exp_m, got;
        pend0 = r0;
        pend1 = r1;
        set_m0(r0, dir0, a0, w0);
        set_m1(r1, dir1, a1, w1);
        if (r0 && r1) exp_m = 1 - model_last;
        else          exp_m = r1 ? 1 : 0;
        for (int c = 0; c < 30 && (pend0 || pend1); c++) begin
            tick();
            if (m0_ack || m1_ack) begin
                chk("rnd_single_ack", {31'b0, m0_ack & m1_ack}, 32'd0);
                got = m1_ack ? 1 : 0;
                chk("rnd_order", got, exp_m);
                if (got == 0) begin
                    if (dir0 == DIR_READ) chk("rnd_rdata_m0", m0_rdata, exp_mem[a0]);
                    else exp_mem[a0] = w0;
                    pend0 = 1'b0;
                    m0_req = 1'b0;
                end else begin
                    if (dir1 == DIR_READ) chk("rnd_rdata_m1", m1_rdata, exp_mem[a1]);
                    else exp_mem[a1] = w1;
                    pend1 = 1'b0;
                    m1_req = 1'b0;
                end
                model_last = got;
                exp_m = 1 - got;
            end
        end
        chk("rnd_all_served", {31'b0, pend0 | pend1}, 32'd0);
        tick();
        tick();
    endtask

    initial begin
        int   last_ack, nacks, got, exp_m;
        logic r0, r1;

        for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
        rst = 1'b1;
        set_m0(1'b0, DIR_READ, 8'h00, 8'h00);
        set_m1(1'b0, DIR_READ, 8'h00, 8'h00);
        tick();
        tick();
        chk("rst_d_req",   {31'b0, d_req},  32'd0);
        chk("rst_m0_ack",  {31'b0, m0_ack}, 32'd0);
        chk("rst_m1_ack",  {31'b0, m1_ack}, 32'd0);
        chk("rst_d_addr",  d_addr,  32'h00);
        chk("rst_d_wdata", d_wdata, 32'h00);
        chk("rst_d_dir",   {31'b0, d_dir},  32'd0);
        rst = 1'b0;

        // Single write then read from master 0
        set_m0(1'b1, DIR_WRITE, 8'h10, 8'hA5);
        tick();
        chk("wr_d_req_t1",  {31'b0, d_req},  32'd1);
        chk("wr_d_addr",    d_addr,  32'h10);
        chk("wr_d_wdata",   d_wdata, 32'hA5);
        chk("wr_d_dir",     {31'b0, d_dir},  32'd1);
        chk("wr_m0_ack_t1", {31'b0, m0_ack}, 32'd0);
        tick();
        chk("wr_m0_ack_t2", {31'b0, m0_ack}, 32'd1);
        chk("wr_m1_ack_t2", {31'b0, m1_ack}, 32'd0);
        exp_mem[8'h10] = 8'hA5;
        m0_req = 1'b0;
        tick();
        chk("wr_release",   {31'b0, d_req},  32'd0);
        chk("wr_ack_pulse", {31'b0, m0_ack}, 32'd0);
        tick();
        set_m0(1'b1, DIR_READ, 8'h10, 8'h00);
        tick();
        chk("rd_d_req_t1",  {31'b0, d_req},  32'd1);
        tick();
        chk("rd_m0_ack_t2", {31'b0, m0_ack}, 32'd1);
        chk("rd_m1_ack_t2", {31'b0, m1_ack}, 32'd0);
        chk("rd_m0_rdata",  m0_rdata, 32'hA5);
        m0_req = 1'b0;
        tick();
        tick();

        // Simultaneous request right after reset: master 0 first, one idle gap
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        set_m0(1'b1, DIR_WRITE, 8'h01, 8'h11);
        set_m1(1'b1, DIR_WRITE, 8'h02, 8'h22);
        tick();
        chk("sim_first_addr", d_addr, 32'h01);
        tick();
        chk("sim_m0_ack", {31'b0, m0_ack}, 32'd1);
        chk("sim_m1_wait", {31'b0, m1_ack}, 32'd0);
        exp_mem[8'h01] = 8'h11;
        m0_req = 1'b0;
        tick();
        chk("sim_gap_low", {31'b0, d_req}, 32'd0);
        tick();
        chk("sim_second_req",  {31'b0, d_req}, 32'd1);
        chk("sim_second_addr", d_addr, 32'h02);
        tick();
        chk("sim_m1_ack", {31'b0, m1_ack}, 32'd1);
        chk("sim_m0_idle", {31'b0, m0_ack}, 32'd0);
        exp_mem[8'h02] = 8'h22;
        m1_req = 1'b0;
        model_last = 1;
        tick();
        tick();
        run_pair(1'b1, 1'b1, DIR_READ, DIR_READ, 8'h01, 8'h02, 8'h00, 8'h00);

        // Sustained contention: strict alternation, one ack every 3 cycles
        set_m0(1'b1, DIR_READ, 8'h01, 8'h00);
        set_m1(1'b1, DIR_READ, 8'h02, 8'h00);
        exp_m = 1 - model_last;
        last_ack = -1;
        nacks = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (m0_ack || m1_ack) begin
                chk("sus_single_ack", {31'b0, m0_ack & m1_ack}, 32'd0);
                got = m1_ack ? 1 : 0;
                chk("sus_order", got, exp_m);
                if (last_ack >= 0) chk("sus_gap", i - last_ack, 32'd3);
                else chk("sus_first", i, 32'd2);
                last_ack = i;
                nacks++;
                model_last = got;
                exp_m = 1 - got;
            end
        end
        chk("sus_count", nacks, 32'd4);
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        tick();

        // Master inputs change after the grant; the latched access must win
        set_m1(1'b1, DIR_WRITE, 8'h05, 8'h33);
        tick();
        m1_addr  = 8'h06;
        m1_wdata = 8'h44;
        chk("chg_d_addr",  d_addr,  32'h05);
        chk("chg_d_wdata", d_wdata, 32'h33);
        tick();
        chk("chg_m1_ack", {31'b0, m1_ack}, 32'd1);
        exp_mem[8'h05] = 8'h33;
        m1_req = 1'b0;
        model_last = 1;
        tick();
        tick();
        run_pair(1'b1, 1'b0, DIR_READ, DIR_READ, 8'h05, 8'h00, 8'h00, 8'h00);
        run_pair(1'b0, 1'b1, DIR_READ, DIR_READ, 8'h00, 8'h06, 8'h00, 8'h00);

        // Reset during BUSY: no ack, d_req drops, master 0 wins next tie
        set_m0(1'b1, DIR_WRITE, 8'h20, 8'h77);
        tick();
        chk("rstb_busy", {31'b0, d_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_req = 1'b0;
        chk("rstb_d_req",  {31'b0, d_req},  32'd0);
        chk("rstb_m0_ack", {31'b0, m0_ack}, 32'd0);
        chk("rstb_m1_ack", {31'b0, m1_ack}, 32'd0);
        exp_mem[8'h20] = 8'h77;  // write was already issued to memory
        model_last = 1;
        run_pair(1'b1, 1'b1, DIR_READ, DIR_READ, 8'h20, 8'h21, 8'h00, 8'h00);

        // Early req drop: access still completes and FSM returns to idle
        set_m0(1'b1, DIR_READ, 8'h10, 8'h00);
        tick();
        chk("drop_busy", {31'b0, d_req}, 32'd1);
        m0_req = 1'b0;
        tick();
        chk("drop_m0_ack", {31'b0, m0_ack}, 32'd1);
        chk("drop_rdata",  m0_rdata, {24'b0, exp_mem[8'h10]});
        tick();
        chk("drop_release", {31'b0, d_req}, 32'd0);
        tick();
        chk("drop_idle1", {31'b0, d_req}, 32'd0);
        tick();
        chk("drop_idle2", {31'b0, d_req}, 32'd0);
        model_last = 0;

        // Random traffic against the round-robin + memory-image model
        for (int n = 0; n < 60; n++) begin
            r0 = 1'b0;
            r1 = 1'b0;
            while (!r0 && !r1) begin
                r0 = 1'($urandom_range(0, 1));
                r1 = 1'($urandom_range(0, 1));
            end
            run_pair(r0, r1,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                     8'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
